ysyx_22050039_fetch_unit: RTL and testbench

Instruction fetch unit for the RV64 NPC core. It owns the program counter, issues single-word read requests to instruction memory over a valid/ready request channel with a separate response strobe, and presents each fetched 32-bit instruction and its PC to the decode stage over a valid/ready handshake. Control-flow changes reported by the decode/execute path (the `pc_wen` result plus target) arrive on the redirect port. The unit flushes in-flight fetches and resumes at the target.

---
 rtl/ysyx_22050039_fetch_unit_if.sv | 38 +++
 rtl/ysyx_22050039_fetch_unit.sv | 107 ++++++++++
 tb/tb_ysyx_22050039_fetch_unit.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050039_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// ysyx_22050039_fetch_unit_if : imem request/response, decode and redirect bus
// Revision 1.0
// ============================================================================
interface ysyx_22050039_fetch_unit_if #(
  parameter int XLEN     = 64,
  parameter int INST_LEN = 32
);
  logic                imem_req_valid;
  logic                imem_req_ready;
  logic [XLEN-1:0]     imem_req_addr;
  logic                imem_resp_valid;
  logic [INST_LEN-1:0] imem_resp_data;
  logic                inst_valid;
  logic                inst_ready;
  logic [INST_LEN-1:0] inst;
  logic [XLEN-1:0]     inst_pc;
  logic                redirect_valid;
  logic [XLEN-1:0]     redirect_pc;
  logic                fetch_fault;
  logic [XLEN-1:0]     fetch_count;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
           fetch_fault, fetch_count,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
           fetch_fault, fetch_count,
    output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
           redirect_valid, redirect_pc
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_22050039_fetch_unit.sv
`default_nettype none
// ============================================================================
// ysyx_22050039_fetch_unit : PC owner, single-outstanding imem fetch, redirect
// Revision 1.0
// ============================================================================
module ysyx_22050039_fetch_unit #(
  parameter int              XLEN     = 64,
  parameter int              INST_LEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
  input  logic                        clk,
  input  logic                        rst,
  ysyx_22050039_fetch_unit_if.master  bus
);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t              state;
  logic [XLEN-1:0]     pc;
  logic [INST_LEN-1:0] inst_buf;
  logic [XLEN-1:0]     inst_pc_buf;
  logic                drop;
  logic [XLEN-1:0]     fetch_count;
  logic                misaligned;

  assign misaligned = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_BOOT;
      pc          <= RESET_PC;
      inst_buf    <= '0;
      inst_pc_buf <= '0;
      drop        <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (state)
        S_BOOT: state <= S_REQ;

        S_REQ: begin
          if (misaligned) begin
            state <= S_FAULT;
          end else begin
            if (bus.redirect_valid) pc <= bus.redirect_pc;
            // An accepted request that races a redirect still carries the old pc.
            if (bus.imem_req_ready) begin
              state <= S_WAIT;
              drop  <= bus.redirect_valid;
            end
          end
        end

        S_WAIT: begin
          if (misaligned) begin
            state <= S_FAULT;
          end else if (bus.imem_resp_valid) begin
            drop <= 1'b0;
            if (bus.redirect_valid || drop) begin
              state <= S_REQ;
              if (bus.redirect_valid) pc <= bus.redirect_pc;
            end else begin
              inst_buf    <= bus.imem_resp_data;
              inst_pc_buf <= pc;
              state       <= S_HOLD;
            end
          end else if (bus.redirect_valid) begin
            drop <= 1'b1;
            pc   <= bus.redirect_pc;
          end
        end

        S_HOLD: begin
          if (misaligned) begin
            state <= S_FAULT;
          end else if (bus.inst_ready) begin
            fetch_count <= fetch_count + XLEN'(1);
            pc          <= bus.redirect_valid ? bus.redirect_pc : pc + XLEN'(4);
            state       <= S_REQ;
          end else if (bus.redirect_valid) begin
            pc    <= bus.redirect_pc;
            state <= S_REQ;
          end
        end

        S_FAULT: state <= S_FAULT;

        default: state <= S_BOOT;
      endcase
    end
  end

  assign bus.imem_req_valid = (state == S_REQ);
  assign bus.inst_valid     = (state == S_HOLD);
  assign bus.fetch_fault    = (state == S_FAULT);
  assign bus.imem_req_addr  = pc;
  assign bus.inst           = inst_buf;
  assign bus.inst_pc        = inst_pc_buf;
  assign bus.fetch_count    = fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050039_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_ysyx_22050039_fetch_unit : directed + randomized self-checking bench
// Revision 1.0
// ============================================================================
module tb_ysyx_22050039_fetch_unit;
  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  bit   mem_const = 1'b1;
  bit   mem_rand  = 1'b0;
  int   mem_lat   = 1;

  always #5 clk = ~clk;

  ysyx_22050039_fetch_unit_if #(.XLEN(64), .INST_LEN(32)) bus ();

  ysyx_22050039_fetch_unit #(.XLEN(64), .INST_LEN(32), .RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (mem_const) return 32'h0000_0013;
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_inst(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (bus.inst_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Instruction memory: one request at a time, response after a chosen delay.
  initial begin : responder
    int          pend;
    logic [63:0] paddr;
    bit          rdy;
    pend = 0;
    paddr = '0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      bus.imem_resp_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.imem_resp_valid = 1'b1;
          bus.imem_resp_data  = mem_word(paddr);
        end
      end
      rdy = (pend == 0) && (!mem_rand || ($urandom_range(0, 2) != 0));
      if (rdy && bus.imem_req_valid) begin
        paddr = bus.imem_req_addr;
        pend  = mem_rand ? int'($urandom_range(1, 4)) : mem_lat;
      end
      bus.imem_req_ready = rdy;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [63:0] exp_pc, exp_cnt, tgt;
    bit          ok, rdy, redir;

    rst = 1'b1;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    tick();
    tick();
    check("rst_req_valid", bus.imem_req_valid, 0);
    check("rst_inst_valid", bus.inst_valid, 0);
    check("rst_fault", bus.fetch_fault, 0);
    check("rst_count", bus.fetch_count, 0);
    check("rst_inst", bus.inst, 0);
    check("rst_inst_pc", bus.inst_pc, 0);
    check("rst_addr", bus.imem_req_addr, RST_PC);

    // Sequential fetch, zero-wait memory returning a NOP.
    bus.inst_ready = 1'b1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("seq_req_valid", bus.imem_req_valid, 1);
      check("seq_req_addr", bus.imem_req_addr, RST_PC + 64'(4 * k));
      tick();
      check("seq_wait_no_inst", bus.inst_valid, 0);
      tick();
      check("seq_inst_valid", bus.inst_valid, 1);
      check("seq_inst_pc", bus.inst_pc, RST_PC + 64'(4 * k));
      check("seq_inst", bus.inst, 32'h13);
    end
    tick();
    check("seq_count", bus.fetch_count, 3);
    check("seq_next_addr", bus.imem_req_addr, RST_PC + 64'd12);

    // Backpressure in HOLD.
    bus.inst_ready = 1'b0;
    tick();
    tick();
    for (int j = 0; j < 6; j++) begin
      check("bp_inst_valid", bus.inst_valid, 1);
      check("bp_no_req", bus.imem_req_valid, 0);
      check("bp_inst_pc", bus.inst_pc, RST_PC + 64'd12);
      check("bp_inst", bus.inst, 32'h13);
      check("bp_count", bus.fetch_count, 3);
      if (j < 5) tick();
    end
    bus.inst_ready = 1'b1;
    tick();
    check("bp_release_count", bus.fetch_count, 4);
    check("bp_release_addr", bus.imem_req_addr, RST_PC + 64'h10);
    mem_const = 1'b0;
    tick();
    tick();
    check("rd_hold_pc", bus.inst_pc, RST_PC + 64'h10);
    check("rd_hold_inst", bus.inst, mem_word(RST_PC + 64'h10));

    // Redirect coinciding with the handshake.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = RST_PC + 64'h100;
    mem_lat = 4;
    tick();
    bus.redirect_valid = 1'b0;
    check("rd_count", bus.fetch_count, 5);
    check("rd_req_valid", bus.imem_req_valid, 1);
    check("rd_req_addr", bus.imem_req_addr, RST_PC + 64'h100);

    // Redirect in the second WAIT cycle of a 4-cycle fetch.
    tick();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = RST_PC + 64'h200;
    tick();
    bus.redirect_valid = 1'b0;
    check("rw_no_inst_a", bus.inst_valid, 0);
    check("rw_no_req_a", bus.imem_req_valid, 0);
    tick();
    check("rw_no_inst_b", bus.inst_valid, 0);
    tick();
    check("rw_drop_no_inst", bus.inst_valid, 0);
    check("rw_req_valid", bus.imem_req_valid, 1);
    check("rw_req_addr", bus.imem_req_addr, RST_PC + 64'h200);
    wait_inst(12, ok);
    check("rw_inst_timeout", ok, 1);
    check("rw_inst_pc", bus.inst_pc, RST_PC + 64'h200);
    check("rw_inst", bus.inst, mem_word(RST_PC + 64'h200));

    // Misaligned redirect while holding an instruction.
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = RST_PC + 64'h102;
    tick();
    bus.redirect_valid = 1'b0;
    check("mis_fault", bus.fetch_fault, 1);
    check("mis_no_inst", bus.inst_valid, 0);
    check("mis_pc_kept", bus.imem_req_addr, RST_PC + 64'h200);
    check("mis_count", bus.fetch_count, 5);
    for (int j = 0; j < 4; j++) begin
      tick();
      check("mis_sticky", bus.fetch_fault, 1);
      check("mis_no_req", bus.imem_req_valid, 0);
    end
    rst = 1'b1;
    #1;
    check("mis_rst_fault", bus.fetch_fault, 0);
    check("mis_rst_addr", bus.imem_req_addr, RST_PC);
    mem_lat = 1;
    tick();
    rst = 1'b0;
    bus.inst_ready = 1'b1;
    tick();
    check("mis_restart_valid", bus.imem_req_valid, 1);
    check("mis_restart_addr", bus.imem_req_addr, RST_PC);
    tick();
    tick();
    check("ar_first_pc", bus.inst_pc, RST_PC);
    mem_lat = 6;
    tick();
    check("ar_req_addr", bus.imem_req_addr, RST_PC + 64'd4);
    check("ar_count", bus.fetch_count, 1);

    // Asynchronous reset in the middle of a WAIT.
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("ar_count_clr", bus.fetch_count, 0);
    check("ar_inst_pc_clr", bus.inst_pc, 0);
    check("ar_inst_clr", bus.inst, 0);
    check("ar_inst_valid", bus.inst_valid, 0);
    check("ar_req_valid", bus.imem_req_valid, 0);
    tick();
    rst = 1'b0;
    wait_inst(30, ok);
    check("ar_inst_timeout", ok, 1);
    check("ar_stale_pc", bus.inst_pc, RST_PC);
    check("ar_stale_inst", bus.inst, mem_word(RST_PC));

    // Randomized traffic against a program-order model.
    rst = 1'b1;
    mem_rand = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.inst_ready = 1'b0;
    repeat (10) tick();
    rst = 1'b0;
    exp_pc  = RST_PC;
    exp_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      tick();
      check("rand_count", bus.fetch_count, exp_cnt);
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 7) == 0)
        tgt = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 1)) * 64'd4;
      else
        tgt = RST_PC + 64'($urandom_range(0, 1023)) * 64'd4;
      if (bus.inst_valid && rdy) begin
        check("rand_inst_pc", bus.inst_pc, exp_pc);
        check("rand_inst", bus.inst, mem_word(exp_pc));
        exp_cnt = exp_cnt + 64'd1;
        exp_pc  = exp_pc + 64'd4;
      end
      if (redir) exp_pc = tgt;
      bus.inst_ready     = rdy;
      bus.redirect_valid = redir;
      bus.redirect_pc    = tgt;
    end
    tick();
    bus.redirect_valid = 1'b0;
    check("rand_final_count", bus.fetch_count, exp_cnt);
    check("rand_no_fault", bus.fetch_fault, 0);
    check("rand_progress", 64'(exp_cnt >= 64'd30), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
